pe_result_drain: RTL and testbench
==================================

// Module: pe_result_drain
// PURPOSE
//  Consumer end of the PE result interface: captures the (NUM1+1-NUM2)-word FP32 result vector on each
//  PE oen pulse, buffers up to two vectors, and streams them one word per cycle over a valid/ready port
//  with a running write address toward the output SRAM. Drives pe_ready back to gate the PE's en.
// PARAMETERS
//  WORDWIDTH  32  bits per FP32 word (opaque; no arithmetic on data)
//  NUM1       14  activation words per channel at PE input
//  NUM2       5   weight words per channel at PE input
//  NOUT       NUM1+1-NUM2 (10)  words per result vector; localparam, not overridable
//  ADDRW      10  output address width
//  BASE       0   address of word 0 of the first vector after start
// PORTS
//  clk        in   1               rising-edge clock
//  rst        in   1               synchronous, active-high reset
//  start      in   1               restart addressing at BASE; honoured only when buffer empty
//  oen        in   1               PE result-valid pulse (one cycle per vector)
//  result     in   NOUT*WORDWIDTH  PE result vector, sampled when oen=1
//  pe_ready   out  1               buffer can accept a vector this cycle
//  out_valid  out  1               out_data/out_addr valid
//  out_ready  in   1               downstream accepts word when out_valid&out_ready
//  out_data   out  WORDWIDTH       one result word
//  out_addr   out  ADDRW           write address of out_data
//  out_last   out  1               out_data is word NOUT-1 of its vector
//  overflow   out  1               sticky: oen arrived while buffer full
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): count=0, word index=0, address=BASE, overflow=0; out_valid=0,
//    out_last=0, out_data=0, out_addr=BASE; pe_ready=1 from the first cycle after reset. Mid-stream reset
//    discards both buffered vectors.
//  - Buffer: 2-entry vector FIFO; count in {0,1,2}. pe_ready = (count!=2), combinational from count.
//  - Capture: oen & pe_ready -> vector written at the edge, count+1. oen & !pe_ready -> vector dropped,
//    overflow<=1 (held until rst). oen with count==2 and a last-word pop in the same cycle is still
//    dropped (no same-cycle slot reuse when full).
//  - Word order: word k = result[(NOUT-k)*WORDWIDTH-1 -: WORDWIDTH], i.e. k=0 is the MS word.
//  - Latency: oen at edge t with count==0 -> out_valid=1 with word 0 in the cycle after t.
//  - Stream: out_valid = (count!=0). out_data/out_addr/out_last derive from head vector and word
//    index; stable while out_valid & !out_ready. Transfer on out_valid&out_ready: index+1, addr+1.
//  - out_last = (index==NOUT-1). On its transfer: index<=0, head popped, count-1; if count stays >0
//    the next vector's word 0 is presented the very next cycle (no bubble).
//  - Simultaneous capture and last pop with count==1: count stays 1, new vector becomes head.
//  - Address: increments by 1 per transfer across vectors; wraps modulo 2^ADDRW silently.
//  - start: when count==0 sets address to BASE at the edge; ignored when count!=0 (no error flag).
//    start and oen in the same cycle with count==0: address reset and capture both take effect.
//  - Throughput: one word/cycle with out_ready=1; sustained PE rate <= one vector per NOUT cycles.
// STRUCTURE
//  - Shared package pe_pkg: WORDWIDTH default, function nout(NUM1,NUM2)=NUM1+1-NUM2, FP32 word typedef.
//  - One sub-module: pe_vec_fifo (2-entry, NOUT*WORDWIDTH wide, push/pop/count, rd pointer 1 bit).
//  - Top holds word index counter, address counter, overflow flag and the output word mux.
// TESTING (NOUT=10, WORDWIDTH=32, BASE=0)
//  1 rst=1 for 2 cycles -> out_valid=0, out_last=0, pe_ready=1, overflow=0, out_addr=0.
//  2 one oen, word k=32'h3F800000+k, out_ready=1 -> out_valid next cycle for exactly 10 cycles,
//    data 3F800000..3F800009, addr 0..9, out_last only with addr 9.
//  3 same vector, out_ready toggling 1,0,0,1 -> data/addr held when stalled; all 10 words, no dups.
//  4 out_ready=0, oen on 3 consecutive cycles -> 2 captured, pe_ready=0 after 2nd, overflow=1 after
//    3rd; then out_ready=1 -> exactly 20 words, addr 0..19.
//  5 count==1, oen coincident with out_last transfer -> next cycle word 0 of new vector at addr 10.
//  6 ADDRW=4: 2 vectors -> addresses 0..15,0..3 (wrap); start while empty -> next vector from 0.
//  7 rst asserted at word 4 of vector 1 with vector 2 buffered -> out_valid=0 next cycle, count=0.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared definitions for the PE result path: default word width, result length helper and word type.
package pe_pkg;

    localparam int DEF_WORDWIDTH = 32;

    typedef logic [DEF_WORDWIDTH-1:0] fp32_t;

    // Valid 1-D correlation length: NUM1 activations against NUM2 weights.
    function automatic int nout(input int num1, input int num2);
        return num1 + 1 - num2;
    endfunction

endpackage

// File: rtl/pe_result_drain_fifo.sv
// Two-entry FIFO of whole PE result vectors; occupancy exported so the drain can throttle the PE.
module pe_vec_fifo #(
    parameter int VW = 320
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [VW-1:0] wdata,
    output logic [VW-1:0] rdata,
    output logic [1:0]    count
);

    logic [VW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy alone says what is meaningful.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/pe_result_drain.sv
// Drains PE result vectors into a word-serial valid/ready stream with a running SRAM write address.
module pe_result_drain
    import pe_pkg::*;
#(
    parameter int WORDWIDTH = DEF_WORDWIDTH,
    parameter int NUM1      = 14,
    parameter int NUM2      = 5,
    parameter int ADDRW     = 10,
    parameter int BASE      = 0,
    localparam int NOUT     = nout(NUM1, NUM2)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      oen,
    input  logic [NOUT*WORDWIDTH-1:0] result,
    output logic                      pe_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WORDWIDTH-1:0]      out_data,
    output logic [ADDRW-1:0]          out_addr,
    output logic                      out_last,
    output logic                      overflow
);

    localparam int IDXW = (NOUT > 1) ? $clog2(NOUT) : 1;

    logic [1:0]                count;
    logic [NOUT*WORDWIDTH-1:0] head;
    logic [IDXW-1:0]           idx;
    logic [ADDRW-1:0]          addr;
    logic [WORDWIDTH-1:0]      word_sel;
    logic                      push;
    logic                      pop;
    logic                      xfer;
    logic                      at_last;

    assign pe_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = oen & pe_ready;
    assign xfer      = out_valid & out_ready;
    assign at_last   = (idx == IDXW'(NOUT - 1));
    assign pop       = xfer & at_last;

    pe_vec_fifo #(
        .VW(NOUT*WORDWIDTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .wdata(result),
        .rdata(head),
        .count(count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (xfer) begin
            idx <= at_last ? '0 : idx + IDXW'(1);
        end
    end

    // A transfer needs a non-empty buffer and start needs an empty one, so they never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= ADDRW'(BASE);
        end else if (start && count == 2'd0) begin
            addr <= ADDRW'(BASE);
        end else if (xfer) begin
            addr <= addr + ADDRW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (oen && !pe_ready) begin
            overflow <= 1'b1;
        end
    end

    // Word 0 is the most significant word of the captured vector.
    always_comb begin
        word_sel = '0;
        for (int k = 0; k < NOUT; k++) begin
            if (idx == IDXW'(k)) word_sel = head[(NOUT-k)*WORDWIDTH-1 -: WORDWIDTH];
        end
    end

    assign out_data = out_valid ? word_sel : '0;
    assign out_addr = addr;
    assign out_last = out_valid & at_last;

endmodule

// File: tb/tb_pe_result_drain.sv
// Bench for pe_result_drain: fixed vector table, directed corner sequences and a random run vs a word-queue model.
module tb_pe_result_drain;
    import pe_pkg::*;

    localparam int NOUT = 10;
    localparam int W    = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              oen = 1'b0;
    logic              out_ready = 1'b0;
    logic [NOUT*W-1:0] result = '0;

    logic         pe_ready, out_valid, out_last, overflow;
    logic [W-1:0] out_data;
    logic [9:0]   out_addr;
    logic         pe_ready4, out_valid4, out_last4, overflow4;
    logic [W-1:0] out_data4;
    logic [3:0]   out_addr4;

    pe_result_drain #(.WORDWIDTH(W), .NUM1(14), .NUM2(5), .ADDRW(10), .BASE(0)) dut (
        .clk(clk), .rst(rst), .start(start), .oen(oen), .result(result),
        .pe_ready(pe_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .out_last(out_last), .overflow(overflow)
    );

    pe_result_drain #(.WORDWIDTH(W), .NUM1(14), .NUM2(5), .ADDRW(4), .BASE(0)) dut4 (
        .clk(clk), .rst(rst), .start(start), .oen(oen), .result(result),
        .pe_ready(pe_ready4), .out_valid(out_valid4), .out_ready(out_ready),
        .out_data(out_data4), .out_addr(out_addr4), .out_last(out_last4), .overflow(overflow4)
    );

    always #5 clk = ~clk;

    fp32_t       cur_w [NOUT];
    fp32_t       wq [$];
    logic [31:0] m_addr = '0;
    bit          m_ovf = 1'b0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        rst, start, oen, rdy;
        logic        v, l, pr, ov;
        logic [9:0]  a;
        logic [31:0] d;
    } row_t;
    row_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_vec(input fp32_t b, input bit rnd);
        for (int k = 0; k < NOUT; k++) begin
            cur_w[k] = rnd ? fp32_t'($urandom) : b + fp32_t'(k);
            result[(NOUT-k)*W-1 -: W] = cur_w[k];
        end
    endtask

    // Model: the buffer is a flat queue of pending words; a vector fits while at most one vector is pending.
    task automatic model_edge();
        int n = wq.size();
        if (rst) begin
            wq.delete();
            m_addr = '0;
            m_ovf  = 1'b0;
        end else begin
            if (n > 0 && out_ready) begin
                void'(wq.pop_front());
                m_addr++;
            end
            if (start && n == 0) m_addr = '0;
            if (oen) begin
                if (n <= NOUT) begin
                    for (int k = 0; k < NOUT; k++) wq.push_back(cur_w[k]);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic check_model();
        int n = wq.size();
        chk("m_valid", 32'(out_valid), 32'(n > 0));
        chk("m_data", out_data, (n > 0) ? wq[0] : 32'h0);
        chk("m_last", 32'(out_last), 32'(n > 0 && (n % NOUT) == 1));
        chk("m_pe_ready", 32'(pe_ready), 32'(n <= NOUT));
        chk("m_overflow", 32'(overflow), 32'(m_ovf));
        chk("m_addr", 32'(out_addr), 32'(m_addr[9:0]));
        chk("m_addr4", 32'(out_addr4), 32'(m_addr[3:0]));
        chk("m_valid4", 32'(out_valid4), 32'(n > 0));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; oen = 1'b0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int nvalid, nlast, guard;
        logic [9:0] last_addr;
        fp32_t got [$];
        bit pat [4];

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 32'h0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd0, 32'h3F800000};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 10'd1, 32'h3F800001};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd1, 32'h3F800001};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd1, 32'h3F800001};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 10'd2, 32'h3F800002};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd2, 32'h3F800002};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 10'd3, 32'h3F800003};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 10'd4, 32'h3F800004};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 32'h0};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 10'd0, 32'h3F800000};

        load_vec(32'h3F800000, 1'b0);
        for (int i = 0; i < 12; i++) begin
            rst = tbl[i].rst; start = tbl[i].start; oen = tbl[i].oen; out_ready = tbl[i].rdy;
            step();
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].v));
            chk($sformatf("tbl%0d_last", i), 32'(out_last), 32'(tbl[i].l));
            chk($sformatf("tbl%0d_pe_ready", i), 32'(pe_ready), 32'(tbl[i].pr));
            chk($sformatf("tbl%0d_overflow", i), 32'(overflow), 32'(tbl[i].ov));
            chk($sformatf("tbl%0d_addr", i), 32'(out_addr), 32'(tbl[i].a));
            chk($sformatf("tbl%0d_data", i), out_data, tbl[i].d);
        end

        // Single vector, downstream always ready.
        do_reset();
        oen = 1'b1; out_ready = 1'b1;
        step();
        oen = 1'b0;
        nvalid = 0; nlast = 0; last_addr = '0;
        for (int c = 0; c < 15; c++) begin
            if (out_valid) begin
                nvalid++;
                if (out_last) begin nlast++; last_addr = out_addr; end
            end
            step();
        end
        chk("single_nvalid", 32'(nvalid), 32'd10);
        chk("single_nlast", 32'(nlast), 32'd1);
        chk("single_last_addr", 32'(last_addr), 32'd9);

        // Stalling downstream: every word once, in order.
        do_reset();
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        oen = 1'b1;
        step();
        oen = 1'b0;
        got.delete();
        for (int c = 0; c < 60; c++) begin
            out_ready = pat[c % 4];
            if (out_valid && out_ready) got.push_back(out_data);
            step();
        end
        chk("stall_nwords", 32'(got.size()), 32'd10);
        for (int j = 0; j < got.size() && j < NOUT; j++)
            chk($sformatf("stall_word%0d", j), got[j], 32'h3F800000 + 32'(j));

        // Three back-to-back vectors into a stalled drain.
        do_reset();
        oen = 1'b1;
        load_vec(0, 1'b1); step();
        load_vec(0, 1'b1); step();
        chk("full_pe_ready", 32'(pe_ready), 32'd0);
        chk("full_no_ovf_yet", 32'(overflow), 32'd0);
        load_vec(0, 1'b1); step();
        chk("full_overflow", 32'(overflow), 32'd1);
        oen = 1'b0; out_ready = 1'b1;
        nvalid = 0; last_addr = '0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) begin nvalid++; last_addr = out_addr; end
            step();
        end
        chk("full_nwords", 32'(nvalid), 32'd20);
        chk("full_last_addr", 32'(last_addr), 32'd19);

        // Capture coincident with the last-word pop of the only vector.
        do_reset();
        load_vec(32'h3F800000, 1'b0);
        oen = 1'b1; out_ready = 1'b1;
        step();
        oen = 1'b0;
        guard = 0;
        while (!out_last && guard < 20) begin step(); guard++; end
        chk("coinc_reached_last", 32'(out_last), 32'd1);
        load_vec(32'h40000000, 1'b0);
        oen = 1'b1;
        step();
        oen = 1'b0;
        chk("coinc_valid", 32'(out_valid), 32'd1);
        chk("coinc_data", out_data, 32'h40000000);
        chk("coinc_addr", 32'(out_addr), 32'd10);

        // Drain the second vector; the 4-bit instance has wrapped. Then restart addressing.
        guard = 0;
        while (out_valid && guard < 20) begin step(); guard++; end
        chk("wrap_drained", 32'(out_valid), 32'd0);
        chk("wrap_addr", 32'(out_addr), 32'd20);
        chk("wrap_addr4", 32'(out_addr4), 32'd4);
        start = 1'b1;
        step();
        start = 1'b0;
        load_vec(32'h41000000, 1'b0);
        oen = 1'b1;
        step();
        oen = 1'b0;
        chk("restart_addr", 32'(out_addr), 32'd0);
        chk("restart_addr4", 32'(out_addr4), 32'd0);
        chk("restart_data", out_data, 32'h41000000);

        // Reset in the middle of a stream with a second vector buffered.
        do_reset();
        oen = 1'b1;
        load_vec(0, 1'b1); step();
        load_vec(0, 1'b1); step();
        oen = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) step();
        chk("midrst_addr_before", 32'(out_addr), 32'd4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_pe_ready", 32'(pe_ready), 32'd1);
        step();
        chk("midrst_stays_empty", 32'(out_valid), 32'd0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            start     = ($urandom_range(0, 15) == 0);
            oen       = ($urandom_range(0, 5) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            load_vec(0, 1'b1);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
